// File: rtl/ray_pkg.sv
// Shared types and constants for the camera ray generator.
package ray_pkg;

  localparam int D_BITS = 32;
  localparam int Q_BITS = 10;

  localparam int RAY_OX = 0;
  localparam int RAY_OY = 1;
  localparam int RAY_OZ = 2;
  localparam int RAY_DX = 3;
  localparam int RAY_DY = 4;
  localparam int RAY_DZ = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } gen_state_t;

endpackage

// File: rtl/raster_counter.sv
// Raster-order pixel position counter. Advances one pixel per enabled cycle
// and flags the end of a row and the end of the frame.
module raster_counter #(
  parameter int H_RES = 32,
  parameter int V_RES = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic row_wrap,
  output logic last
);

  localparam int PX_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int PY_W = (V_RES > 1) ? $clog2(V_RES) : 1;

  logic [PX_W-1:0] px_q, px_d;
  logic [PY_W-1:0] py_q, py_d;

  assign row_wrap = (px_q == PX_W'(H_RES - 1));
  assign last     = row_wrap && (py_q == PY_W'(V_RES - 1));

  // NOTE: defaulting every _d to its _q first keeps this block latch-free.
  always_comb begin
    px_d = px_q;
    py_d = py_q;
    if (clear) begin
      px_d = '0;
      py_d = '0;
    end else if (en) begin
      if (row_wrap) begin
        px_d = '0;
        py_d = last ? '0 : py_q + 1'b1;
      end else begin
        px_d = px_q + 1'b1;
      end
    end
  end

  // NOTE: state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      px_q <= '0;
      py_q <= '0;
    end else begin
      px_q <= px_d;
      py_q <= py_d;
    end
  end

endmodule

// File: rtl/ray_generator.sv
// Camera ray source: emits one primary ray per pixel in raster order into the
// ray tracer input FIFO, honouring in_full backpressure.
module ray_generator
  import ray_pkg::*;
#(
  parameter int H_RES    = 32,
  parameter int V_RES    = 32,
  parameter int CNT_BITS = $clog2(H_RES * V_RES + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [D_BITS-1:0]   cam_pos  [3],
  input  logic [D_BITS-1:0]   dir_base [3],
  input  logic [D_BITS-1:0]   step_x,
  input  logic [D_BITS-1:0]   step_y,
  input  logic                in_full,
  output logic                in_wr_en,
  output logic [D_BITS-1:0]   ray_out  [6],
  output logic                busy,
  output logic                done,
  output logic [CNT_BITS-1:0] ray_count
);

  gen_state_t          state_q, state_d;
  logic [D_BITS-1:0]   org_q [3];
  logic [D_BITS-1:0]   org_d [3];
  logic [D_BITS-1:0]   dir_x_q, dir_x_d, dir_y_q, dir_y_d, dir_z_q, dir_z_d;
  logic [D_BITS-1:0]   base_x_q, base_x_d, step_x_q, step_x_d, step_y_q, step_y_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                clear, row_wrap, last;

  raster_counter #(
    .H_RES(H_RES),
    .V_RES(V_RES)
  ) u_raster (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear),
    .en      (in_wr_en),
    .row_wrap(row_wrap),
    .last    (last)
  );

  always_comb begin
    state_d  = state_q;
    org_d    = org_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    dir_z_d  = dir_z_q;
    base_x_d = base_x_q;
    step_x_d = step_x_q;
    step_y_d = step_y_q;
    count_d  = count_q;
    clear    = 1'b0;
    in_wr_en = (state_q == RUN) && !in_full;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          org_d    = cam_pos;
          dir_x_d  = dir_base[0];
          dir_y_d  = dir_base[1];
          dir_z_d  = dir_base[2];
          base_x_d = dir_base[0];
          step_x_d = step_x;
          step_y_d = step_y;
          count_d  = '0;
          clear    = 1'b1;
        end
      end
      RUN: begin
        if (in_wr_en) begin
          count_d = count_q + 1'b1;
          if (row_wrap) begin
            dir_x_d = base_x_q;
            dir_y_d = dir_y_q + step_y_q;
          end else begin
            dir_x_d = dir_x_q + step_x_q;
          end
          if (last) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      // NOTE: these are plain registers, not RAM, so they take reset like any flop.
      org_q    <= '{default: '0};
      dir_x_q  <= '0;
      dir_y_q  <= '0;
      dir_z_q  <= '0;
      base_x_q <= '0;
      step_x_q <= '0;
      step_y_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      org_q    <= org_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
      dir_z_q  <= dir_z_d;
      base_x_q <= base_x_d;
      step_x_q <= step_x_d;
      step_y_q <= step_y_d;
      count_q  <= count_d;
    end
  end

  assign ray_out[RAY_OX] = org_q[0];
  assign ray_out[RAY_OY] = org_q[1];
  assign ray_out[RAY_OZ] = org_q[2];
  assign ray_out[RAY_DX] = dir_x_q;
  assign ray_out[RAY_DY] = dir_y_q;
  assign ray_out[RAY_DZ] = dir_z_q;
  assign busy            = (state_q == RUN);
  assign done            = (state_q == DONE);
  assign ray_count       = count_q;

endmodule

// File: doc/ray_generator.md
# ray_generator

Camera ray source that produces one primary ray per pixel, in raster order, and pushes each ray into the ray tracer input FIFO through its `in_wr_en` / `ray_in` / `in_full` write port. It replaces the testbench's preloaded ray memory with on-chip generation. It sits upstream of `ray_tracer_top`. A single `start` pulse emits `H_RES*V_RES` rays, obeys FIFO backpressure, then pulses `done`.

## Interface
- `D_BITS`, 32, fixed-point word width (signed two's complement)
- `Q_BITS`, 10, fractional bits; 1.0 = `0x400`
- `H_RES`, 32, pixels per row
- `V_RES`, 32, rows per frame
- `CNT_BITS`, `$clog2(H_RES*V_RES+1)`, ray counter width

Ports:
- `clock`  in  1  single clock; all logic on posedge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle request to begin a frame; sampled only in IDLE
- `cam_pos[2:0]`  in  D_BITS each  ray origin x,y,z, shared by all rays
- `dir_base[2:0]`  in  D_BITS each  direction of pixel (0,0)
- `step_x`  in  D_BITS  added to direction x per pixel step
- `step_y`  in  D_BITS  added to direction y per row step
- `in_full`  in  1  FIFO full from `ray_tracer_top`
- `in_wr_en`  out  1  FIFO write strobe
- `ray_out[5:0]`  out  D_BITS each  [0..2] origin x,y,z; [3..5] direction x,y,z; connects to `ray_in`
- `busy`  out  1  high in RUN
- `done`  out  1  one-cycle pulse at frame end
- `ray_count`  out  CNT_BITS  rays written this frame

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN when `start` = 1. On that edge:
  - capture `cam_pos`, `dir_base`, `step_x`, `step_y` into registers;
  - set px = py = 0, `ray_count` = 0;
  - load the direction registers with `dir_base`.
- Input changes after capture are ignored until the next frame.
- RUN: `in_wr_en = !in_full` (combinational). `ray_out` always shows the registered current ray.
- On each edge where `in_wr_en` = 1:
  - `ray_count` += 1.
  - If px < H_RES-1: px += 1, dir_x += `step_x`.
  - Else: px = 0, dir_x = captured `dir_base[0]`, py += 1, dir_y += `step_y`.
  - dir_z and the origin never change.
- RUN → DONE on the write of pixel (H_RES-1, V_RES-1).
- DONE: `done` = 1 for exactly one cycle, then IDLE unconditionally. `start` asserted in DONE is ignored.
- `start` in RUN or DONE has no effect.
- Arithmetic: plain D_BITS two's-complement addition. Overflow wraps; there is no saturation.
- `ray_count` holds its final value in IDLE until the next `start`.

## Timing
- Reset values: state IDLE; `in_wr_en`, `busy`, `done` = 0; `ray_out` all 0; `ray_count` = 0; internal counters 0.
- Reset wins over every other event, including in RUN mid-frame. The frame is abandoned and nothing is resumed.
- First ray: `in_wr_en` can go high in the cycle after `start` is sampled.
- Throughput: one ray per cycle while `in_full` = 0.
- Backpressure: while `in_full` = 1, `in_wr_en` = 0 and `ray_out` and all counters hold. No ray is dropped or duplicated.
- `in_full` changing in the same cycle as the last write: the write occurs only if `in_full` = 0 in that cycle.
- `done` is asserted the cycle after the final write. `busy` drops in that same cycle.
- Minimum frame time is H_RES*V_RES + 2 cycles from the `start` edge to the return to IDLE.

## Structure
- Shared package `ray_pkg`:
  - `D_BITS`, `Q_BITS`;
  - ray word index constants `RAY_OX`, `RAY_OY`, `RAY_OZ`, `RAY_DX`, `RAY_DY`, `RAY_DZ` (0..5);
  - `gen_state_t` enum {IDLE, RUN, DONE}.
- One sub-module, `raster_counter`:
  - px/py counters with enable;
  - outputs `row_wrap` (px == H_RES-1) and `last` (row_wrap && py == V_RES-1).
- Direction accumulators, the FSM and the write logic live in `ray_generator`.

## Test plan
1. Reset: assert `reset` for 2 cycles with random inputs. Expect every output at 0, state IDLE, and `in_wr_en` never high.
2. Basic frame:
   - Stimulus: H_RES=4, V_RES=2, `in_full`=0, `cam_pos`=(0,0,0), `dir_base`=(0,0,0x400), `step_x`=`step_y`=0x40, `start` at cycle 0.
   - Expect writes on cycles 1–8 with dir_x 0,0x40,0x80,0xC0,0,0x40,0x80,0xC0 and dir_y 0×4 then 0x40×4.
   - Expect dir_z = 0x400 throughout, `done` on cycle 9, `ray_count`=8.
3. Backpressure: same frame with `in_full`=1 on cycles 3–5. Expect `in_wr_en`=0 and `ray_out` frozen on those cycles, 8 distinct rays in order, `done` on cycle 12.
4. Ignored inputs:
   - Pulse `start` and change `dir_base`/`step_x` mid-frame. Expect the sequence identical to test 2.
   - Pulse `start` during DONE. Expect no new frame.
5. Reset mid-frame: assert `reset` after the 3rd write. Expect IDLE and zeroed outputs next cycle. A new `start` restarts at pixel (0,0) with `ray_count`=0.
6. Wrap: `dir_base[0]`=0x7FFFFFC0, `step_x`=0x40. Expect the second ray's dir_x = 0x80000000.
